// File: rtl/apb_bridge_rr_arbiter.sv
// Two-port round-robin command arbiter driving one non-pipelined AHB-lite
// transfer at a time into an AHB-to-APB bridge, with per-port response pulses.
module apb_bridge_rr_arbiter #(
  parameter int ADDRWIDTH = 16,
  parameter int DATAWIDTH = 32
) (
  input  logic                 HCLK,
  input  logic                 HRESETn,
  input  logic                 req0_valid,
  input  logic                 req0_write,
  input  logic [ADDRWIDTH-1:0] req0_addr,
  input  logic [DATAWIDTH-1:0] req0_wdata,
  output logic                 req0_ready,
  output logic                 resp0_valid,
  output logic [DATAWIDTH-1:0] resp0_rdata,
  output logic                 resp0_err,
  input  logic                 req1_valid,
  input  logic                 req1_write,
  input  logic [ADDRWIDTH-1:0] req1_addr,
  input  logic [DATAWIDTH-1:0] req1_wdata,
  output logic                 req1_ready,
  output logic                 resp1_valid,
  output logic [DATAWIDTH-1:0] resp1_rdata,
  output logic                 resp1_err,
  output logic                 M_HSEL,
  output logic [ADDRWIDTH-1:0] M_HADDR,
  output logic [1:0]           M_HTRANS,
  output logic                 M_HWRITE,
  output logic [2:0]           M_HSIZE,
  output logic [3:0]           M_HPROT,
  output logic [DATAWIDTH-1:0] M_HWDATA,
  output logic                 M_HREADY,
  input  logic                 M_HREADYOUT,
  input  logic [DATAWIDTH-1:0] M_HRDATA,
  input  logic                 M_HRESP,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t               state_q;
  logic                 last_grant_q;
  logic                 grant_q;
  logic                 hsel_q;
  logic [ADDRWIDTH-1:0] haddr_q;
  logic [1:0]           htrans_q;
  logic                 hwrite_q;
  logic [DATAWIDTH-1:0] hwdata_q;
  logic [1:0]           resp_valid_q;
  logic [1:0]           resp_err_q;
  logic [DATAWIDTH-1:0] resp0_rdata_q;
  logic [DATAWIDTH-1:0] resp1_rdata_q;

  logic                 grant_vld_d;
  logic                 grant_d;
  logic                 write_d;
  logic [ADDRWIDTH-1:0] addr_d;
  logic [DATAWIDTH-1:0] wdata_d;

  // On a tie the requester that did not win last time takes the bus.
  always_comb begin
    grant_vld_d = (state_q == IDLE) && (req0_valid || req1_valid);
    grant_d     = req1_valid && (!req0_valid || !last_grant_q);
    write_d     = grant_d ? req1_write : req0_write;
    addr_d      = grant_d ? req1_addr  : req0_addr;
    wdata_d     = grant_d ? req1_wdata : req0_wdata;
  end

  // Ready is a same-cycle acknowledge; gating with HRESETn keeps it low in reset.
  assign req0_ready = HRESETn && grant_vld_d && !grant_d;
  assign req1_ready = HRESETn && grant_vld_d && grant_d;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q       <= IDLE;
      last_grant_q  <= 1'b1;
      grant_q       <= 1'b0;
      hsel_q        <= 1'b0;
      haddr_q       <= '0;
      htrans_q      <= 2'b00;
      hwrite_q      <= 1'b0;
      hwdata_q      <= '0;
      resp_valid_q  <= 2'b00;
      resp_err_q    <= 2'b00;
      resp0_rdata_q <= '0;
      resp1_rdata_q <= '0;
    end else begin
      resp_valid_q <= 2'b00;
      case (state_q)
        IDLE: begin
          if (grant_vld_d) begin
            grant_q      <= grant_d;
            last_grant_q <= grant_d;
            hsel_q       <= 1'b1;
            htrans_q     <= 2'b10;
            haddr_q      <= {addr_d[ADDRWIDTH-1:2], 2'b00};
            hwrite_q     <= write_d;
            hwdata_q     <= wdata_d;
            state_q      <= ADDR;
          end
        end
        ADDR: begin
          hsel_q   <= 1'b0;
          htrans_q <= 2'b00;
          state_q  <= DATA;
        end
        DATA: begin
          // An ERROR response with HREADYOUT low is only the first phase; wait it out.
          if (M_HREADYOUT) begin
            state_q               <= IDLE;
            resp_valid_q[grant_q] <= 1'b1;
            resp_err_q[grant_q]   <= M_HRESP;
            if (grant_q) resp1_rdata_q <= hwrite_q ? '0 : M_HRDATA;
            else         resp0_rdata_q <= hwrite_q ? '0 : M_HRDATA;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign M_HSEL      = hsel_q;
  assign M_HADDR     = haddr_q;
  assign M_HTRANS    = htrans_q;
  assign M_HWRITE    = hwrite_q;
  assign M_HWDATA    = hwdata_q;
  assign M_HSIZE     = 3'b010;
  assign M_HPROT     = 4'b0011;
  assign M_HREADY    = M_HREADYOUT;
  assign busy        = (state_q != IDLE);
  assign resp0_valid = resp_valid_q[0];
  assign resp1_valid = resp_valid_q[1];
  assign resp0_err   = resp_err_q[0];
  assign resp1_err   = resp_err_q[1];
  assign resp0_rdata = resp0_rdata_q;
  assign resp1_rdata = resp1_rdata_q;

endmodule

// File: tb/tb_apb_bridge_rr_arbiter.sv
// Randomized bench for apb_bridge_rr_arbiter: a transaction-level model plans each
// transfer (grant, wait states, data, error) and a monitor scoreboards the responses.
module tb_apb_bridge_rr_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn;
  logic req0_valid, req0_write, req0_ready, resp0_valid, resp0_err;
  logic req1_valid, req1_write, req1_ready, resp1_valid, resp1_err;
  logic [AW-1:0] req0_addr, req1_addr, M_HADDR;
  logic [DW-1:0] req0_wdata, req1_wdata, resp0_rdata, resp1_rdata, M_HWDATA, M_HRDATA;
  logic M_HSEL, M_HWRITE, M_HREADY, M_HREADYOUT, M_HRESP, busy;
  logic [1:0] M_HTRANS;
  logic [2:0] M_HSIZE;
  logic [3:0] M_HPROT;

  apb_bridge_rr_arbiter #(.ADDRWIDTH(AW), .DATAWIDTH(DW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready), .resp0_valid(resp0_valid),
    .resp0_rdata(resp0_rdata), .resp0_err(resp0_err),
    .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready), .resp1_valid(resp1_valid),
    .resp1_rdata(resp1_rdata), .resp1_err(resp1_err),
    .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HWRITE(M_HWRITE),
    .M_HSIZE(M_HSIZE), .M_HPROT(M_HPROT), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY),
    .M_HREADYOUT(M_HREADYOUT), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP), .busy(busy)
  );

  always #5 HCLK = ~HCLK;

  int cyc = 0;
  always @(posedge HCLK) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, req, cyc);
    end
  endtask

  // Pending commands held by each requester (valid stays up until accepted or withdrawn).
  logic [1:0]    pv, pw;
  logic [AW-1:0] pa [2];
  logic [DW-1:0] pd [2];

  // Transaction-level model of the transfer in flight.
  bit            act;
  int            t, w, end_c, ntx;
  logic          lg, cw, cerr;
  logic [AW-1:0] ca;
  logic [DW-1:0] cd, crd;

  typedef struct {
    int            port;
    logic [DW-1:0] rdata;
    logic          err;
    int            at;
  } exp_t;
  exp_t sbq[$];

  logic [DW-1:0] hold_rd [2];
  logic          hold_err [2];

  // One bus cycle: called right after a falling edge; cycle index is cyc.
  task automatic step(input bit gen);
    int       c, g;
    bit       idle, in_addr, in_data, last;
    logic [1:0] exp_rdy;
    c = cyc;
    chk("busy", 64'(busy), 64'(act && c > t && c < end_c));
    idle = !act || c >= end_c;
    for (int i = 0; i < 2; i++) begin
      if (!pv[i]) begin
        if (gen && ntx >= 2 && $urandom_range(0, 2) == 0) begin
          pv[i] = 1'b1;
          pw[i] = 1'($urandom_range(0, 1));
          pa[i] = 16'($urandom);
          pd[i] = $urandom;
        end
      end else if (gen && ntx >= 2 && $urandom_range(0, 19) == 0) begin
        pv[i] = 1'b0;
      end
    end
    req0_valid = pv[0];
    req0_write = pv[0] ? pw[0] : 1'($urandom_range(0, 1));
    req0_addr  = pv[0] ? pa[0] : 16'($urandom);
    req0_wdata = pv[0] ? pd[0] : $urandom;
    req1_valid = pv[1];
    req1_write = pv[1] ? pw[1] : 1'($urandom_range(0, 1));
    req1_addr  = pv[1] ? pa[1] : 16'($urandom);
    req1_wdata = pv[1] ? pd[1] : $urandom;

    exp_rdy = 2'b00;
    if (idle && (pv[0] || pv[1])) begin
      if (pv[0] && pv[1]) g = (lg == 1'b1) ? 0 : 1;
      else                g = pv[1] ? 1 : 0;
      exp_rdy[g] = 1'b1;
      lg    = 1'(g);
      act   = 1'b1;
      t     = c;
      w     = (ntx == 0) ? 1 : (ntx == 1) ? 0 : $urandom_range(0, 5);
      cerr  = (ntx < 2) ? 1'b0 : ($urandom_range(0, 4) == 0);
      crd   = (ntx == 1) ? 32'hDEAD_BEEF : $urandom;
      cw    = pw[g];
      ca    = pa[g];
      cd    = pd[g];
      end_c = c + 3 + w;
      sbq.push_back('{port: g, rdata: (cw ? '0 : crd), err: cerr, at: end_c});
      pv[g] = 1'b0;
      ntx++;
    end

    in_addr = act && c == t + 1;
    in_data = act && c >= t + 2 && c <= t + 2 + w;
    last    = act && c == t + 2 + w;
    chk("hsel", 64'(M_HSEL), 64'(in_addr));
    chk("htrans", 64'(M_HTRANS), in_addr ? 64'd2 : 64'd0);
    if (in_addr) begin
      chk("haddr", 64'(M_HADDR), 64'({ca[AW-1:2], 2'b00}));
      chk("hwrite", 64'(M_HWRITE), 64'(cw));
    end
    if (in_data) chk("hwdata", 64'(M_HWDATA), 64'(cd));
    chk("hsize_hprot", 64'({M_HSIZE, M_HPROT}), 64'({3'b010, 4'b0011}));

    M_HREADYOUT = in_data ? last : 1'($urandom_range(0, 1));
    M_HRESP     = last ? cerr : 1'($urandom_range(0, 1));
    M_HRDATA    = last ? crd : $urandom;
    #1;
    chk("req0_ready", 64'(req0_ready), 64'(exp_rdy[0]));
    chk("req1_ready", 64'(req1_ready), 64'(exp_rdy[1]));
    chk("hready_copy", 64'(M_HREADY), 64'(M_HREADYOUT));
  endtask

  // Response monitor / scoreboard.
  initial begin
    exp_t e;
    int   c, p;
    forever begin
      @(negedge HCLK);
      c = cyc;
      chk("resp_exclusive", 64'(resp0_valid && resp1_valid), 64'd0);
      while (sbq.size() > 0 && sbq[0].at < c) begin
        e = sbq.pop_front();
        checks++;
        failures++;
        $display("FAIL resp_missing actual=none required=port%0d@cycle%0d", e.port, e.at);
      end
      if (resp0_valid || resp1_valid) begin
        p = resp1_valid ? 1 : 0;
        if (sbq.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL resp_unexpected actual=port%0d required=none cycle=%0d", p, c);
        end else begin
          e = sbq.pop_front();
          chk("resp_port", 64'(p), 64'(e.port));
          chk("resp_cycle", 64'(c), 64'(e.at));
          hold_rd[e.port]  = e.rdata;
          hold_err[e.port] = e.err;
          $display("resp port=%0d rdata=%h err=%0d cycle=%0d", p,
                   p ? resp1_rdata : resp0_rdata, p ? resp1_err : resp0_err, c);
        end
      end
      chk("resp0_rdata", 64'(resp0_rdata), 64'(hold_rd[0]));
      chk("resp0_err", 64'(resp0_err), 64'(hold_err[0]));
      chk("resp1_rdata", 64'(resp1_rdata), 64'(hold_rd[1]));
      chk("resp1_err", 64'(resp1_err), 64'(hold_err[1]));
    end
  end

  task automatic check_all_zero(input string tag);
    chk({tag, "_hsel"}, 64'(M_HSEL), 64'd0);
    chk({tag, "_htrans"}, 64'(M_HTRANS), 64'd0);
    chk({tag, "_haddr"}, 64'(M_HADDR), 64'd0);
    chk({tag, "_hwrite"}, 64'(M_HWRITE), 64'd0);
    chk({tag, "_hwdata"}, 64'(M_HWDATA), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_ready"}, 64'({req0_ready, req1_ready}), 64'd0);
    chk({tag, "_rvalid"}, 64'({resp0_valid, resp1_valid}), 64'd0);
    chk({tag, "_rdata"}, 64'({resp0_rdata, resp1_rdata}), 64'd0);
    chk({tag, "_rerr"}, 64'({resp0_err, resp1_err}), 64'd0);
  endtask

  task automatic reset_model();
    act = 1'b0; t = 0; w = 0; end_c = 0; lg = 1'b1; pv = 2'b00; pw = 2'b00;
    sbq.delete();
    for (int i = 0; i < 2; i++) begin hold_rd[i] = '0; hold_err[i] = 1'b0; end
  endtask

  task automatic drain();
    bit done = 0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge HCLK);
      step(1'b0);
      done = (pv == 2'b00) && (!act || cyc >= end_c) && (sbq.size() == 0);
    end
    chk("drain_timeout", 64'(done), 64'd1);
  endtask

  initial begin
    bit found;
    HRESETn = 1'b0;
    {req0_valid, req0_write, req1_valid, req1_write} = '0;
    req0_addr = '0; req1_addr = '0; req0_wdata = '0; req1_wdata = '0;
    M_HREADYOUT = 1'b1; M_HRESP = 1'b0; M_HRDATA = '0;
    ntx = 0;
    reset_model();
    repeat (3) @(negedge HCLK);
    check_all_zero("reset");

    // First a tie: req0 write 0x0013 (1 wait), then req1 read 0x0040 (0 waits).
    pv = 2'b11; pw = 2'b01;
    pa[0] = 16'h0013; pd[0] = 32'hA5A5_0001;
    pa[1] = 16'h0040; pd[1] = 32'h1234_5678;
    @(negedge HCLK);
    HRESETn = 1'b1;
    step(1'b1);
    for (int k = 0; k < 4000; k++) begin
      @(negedge HCLK);
      step(1'b1);
    end
    drain();

    // Reset while the transfer sits in DATA.
    pv[0] = 1'b1; pw[0] = 1'b0; pa[0] = 16'h0104; pd[0] = $urandom;
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge HCLK);
      step(1'b0);
      found = act && cyc == t + 2;
    end
    chk("reach_data", 64'(found), 64'd1);
    #2;
    HRESETn = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0;
    reset_model();
    #1;
    check_all_zero("midreset");
    repeat (2) @(negedge HCLK);
    check_all_zero("held_reset");

    // After release, a tie goes to requester 0 again.
    @(negedge HCLK);
    HRESETn = 1'b1;
    pv = 2'b11; pw = 2'b10;
    pa[0] = 16'h0200; pd[0] = $urandom;
    pa[1] = 16'h0300; pd[1] = $urandom;
    step(1'b0);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
